// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared FSM state encodings and fetch constants.
package pc_fetch_unit_pkg;
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_HOLD = 2'd3} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: single-outstanding instruction memory req/gnt/rvalid bus.
interface pc_fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  modport master (output im_req, output im_addr, input im_gnt, input im_rvalid, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_gnt, output im_rvalid, output im_rdata);
endinterface

// File: rtl/pc_fetch_unit_fetch_ctrl_fsm.sv
// fetch_ctrl_fsm: fetch sequencing state register and request/capture/advance strobes.
module fetch_ctrl_fsm
  import pc_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         gnt,
  input  logic         rvalid,
  input  logic         dec_ready,
  input  logic         mis,
  output fetch_state_t state,
  output logic         im_req,
  output logic         capture,
  output logic         advance,
  output logic         trap
);
  fetch_state_t state_n;
  always_ff @(posedge clk)
    if (!rstn) state <= S_BOOT;
    else state <= state_n;
  // mis only matters in S_BOOT and on acceptance; it routes straight back to S_HOLD with a nop
  always_comb begin
    state_n = state == S_BOOT ? (mis ? S_HOLD : S_REQ) :
              state == S_REQ  ? (gnt ? S_WAIT : S_REQ) :
              state == S_WAIT ? (rvalid ? S_HOLD : S_WAIT) :
              (dec_ready && !mis) ? S_REQ : S_HOLD;
    im_req  = state == S_REQ;
    capture = state == S_WAIT && rvalid;
    advance = state == S_HOLD && dec_ready;
    trap    = mis && (state == S_BOOT || advance);
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, instruction fetch and decode handoff.
// FETCH_MISALIGN_EN turns misaligned PCs into flagged nops instead of masking them.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [31:0]          npc,
  pc_fetch_unit_if.master      im,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [31:0]          inst_pc,
  input  logic                 dec_ready,
  output logic [31:0]          pc,
  output logic                 fetch_err,
  output logic [CNT_W-1:0]     fetch_cnt
);
  fetch_state_t state;
  logic         capture, advance, trap, mis;
  logic [31:0]  npc_eff, trap_pc;
`ifdef FETCH_MISALIGN_EN
  assign trap_pc = state == S_BOOT ? pc : npc;
  assign mis     = trap_pc[1:0] != 2'b00;
  assign npc_eff = npc;
  always_ff @(posedge clk)
    if (!rstn) fetch_err <= 1'b0;
    else if (trap) fetch_err <= 1'b1;
    else if (advance) fetch_err <= 1'b0;
`else
  assign trap_pc   = pc;
  assign mis       = 1'b0;
  assign npc_eff   = npc & ~32'h3;
  assign fetch_err = 1'b0;
`endif
  fetch_ctrl_fsm u_fsm (
    .clk       (clk),
    .rstn      (rstn),
    .gnt       (im.im_gnt),
    .rvalid    (im.im_rvalid),
    .dec_ready (dec_ready),
    .mis       (mis),
    .state     (state),
    .im_req    (im.im_req),
    .capture   (capture),
    .advance   (advance),
    .trap      (trap)
  );
  assign im.im_addr = pc;
  assign inst_valid = state == S_HOLD;
  always_ff @(posedge clk)
    if (!rstn) begin
      pc        <= RESET_PC;
      inst      <= '0;
      inst_pc   <= '0;
      fetch_cnt <= '0;
    end else begin
      if (advance) begin
        pc        <= npc_eff;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
      if (capture || trap) begin
        inst    <= trap ? NOP : im.im_rdata;
        inst_pc <= trap ? trap_pc : pc;
      end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch sequencing, stalls, reset and counter wrap.
module tb_pc_fetch_unit;
  localparam logic [31:0] K = 32'hDEAD_0000;
  logic        clk = 0, rstn = 0;
  logic        dec_ready = 1, gnt_en = 1, rv_en = 1, stray = 0, pend = 0;
  logic        npc_ovr_en = 0;
  logic [31:0] npc_ovr = '0, paddr = '0, npc;
  logic        inst_valid, fetch_err;
  logic [31:0] inst, inst_pc, pc, fetch_cnt;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  pc_fetch_unit_if im ();
  pc_fetch_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .npc        (npc),
    .im         (im),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .dec_ready  (dec_ready),
    .pc         (pc),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );
  assign npc          = npc_ovr_en ? npc_ovr : pc + 32'd4;
  assign im.im_gnt    = gnt_en;
  assign im.im_rvalid = (pend & rv_en) | stray;
  assign im.im_rdata  = paddr ^ K;
  always @(posedge clk)
    if (!rstn) pend <= 1'b0;
    else if (im.im_req && im.im_gnt) begin
      pend  <= 1'b1;
      paddr <= im.im_addr;
    end else if (im.im_rvalid) pend <= 1'b0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !inst_valid; i++) tick();
    check("wait_valid", {31'b0, inst_valid}, 32'd1);
  endtask
  initial begin
    tick();
    tick();
    check("rst_pc", pc, 32'h3000);
    check("rst_req", {31'b0, im.im_req}, 0);
    check("rst_valid", {31'b0, inst_valid}, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_err", {31'b0, fetch_err}, 0);
    check("rst_cnt", fetch_cnt, 0);
    rstn = 1;
    tick();
    check("t1_req", {31'b0, im.im_req}, 1);
    check("t1_addr", im.im_addr, 32'h3000);
    tick();
    check("t1_wait_req", {31'b0, im.im_req}, 0);
    check("t1_wait_valid", {31'b0, inst_valid}, 0);
    tick();
    check("t1_valid0", {31'b0, inst_valid}, 1);
    check("t1_inst0", inst, 32'hDEAD_3000);
    check("t1_inst_pc0", inst_pc, 32'h3000);
    tick();
    check("t1_pc1", pc, 32'h3004);
    check("t1_addr1", im.im_addr, 32'h3004);
    check("t1_cnt1", fetch_cnt, 1);
    tick();
    tick();
    check("t1_inst_pc1", inst_pc, 32'h3004);
    check("t1_inst1", inst, 32'hDEAD_3004);
    tick();
    check("t1_cnt2", fetch_cnt, 2);
    check("t1_pc2", pc, 32'h3008);
    rstn = 0;
    gnt_en = 0;
    tick();
    rstn = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_req", {31'b0, im.im_req}, 1);
      check("t2_addr", im.im_addr, 32'h3000);
      check("t2_valid", {31'b0, inst_valid}, 0);
      tick();
    end
    gnt_en = 1;
    dec_ready = 0;
    npc_ovr = 32'h3040;
    npc_ovr_en = 1;
    wait_valid(10);
    for (int i = 0; i < 4; i++) begin
      check("t3_inst", inst, 32'hDEAD_3000);
      check("t3_inst_pc", inst_pc, 32'h3000);
      check("t3_pc", pc, 32'h3000);
      tick();
    end
    dec_ready = 1;
    tick();
    npc_ovr_en = 0;
    check("t3_pc", pc, 32'h3040);
    check("t3_addr", im.im_addr, 32'h3040);
    check("t3_req", {31'b0, im.im_req}, 1);
    rv_en = 0;
    tick();
    check("t4_wait_req", {31'b0, im.im_req}, 0);
    rstn = 0;
    tick();
    check("t4_pc", pc, 32'h3000);
    check("t4_valid", {31'b0, inst_valid}, 0);
    check("t4_req", {31'b0, im.im_req}, 0);
    check("t4_cnt", fetch_cnt, 0);
    rstn = 1;
    rv_en = 1;
    stray = 1;
    tick();
    stray = 0;
    check("t4_stray_valid", {31'b0, inst_valid}, 0);
    check("t4_stray_inst", inst, 0);
    check("t4_boot_req", {31'b0, im.im_req}, 1);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    check("t5_pre", fetch_cnt, 32'hFFFF_FFFF);
    wait_valid(10);
    tick();
    check("t5_wrap", fetch_cnt, 0);
    check("t5_pc", pc, 32'h3004);
    wait_valid(10);
    npc_ovr = 32'h3002;
    npc_ovr_en = 1;
    tick();
`ifdef FETCH_MISALIGN_EN
    dec_ready = 0;
    check("t6_valid", {31'b0, inst_valid}, 1);
    check("t6_req", {31'b0, im.im_req}, 0);
    check("t6_inst", inst, 0);
    check("t6_inst_pc", inst_pc, 32'h3002);
    check("t6_err", {31'b0, fetch_err}, 1);
    check("t6_pc", pc, 32'h3002);
    npc_ovr = 32'h3008;
    dec_ready = 1;
    tick();
    check("t6_err_clr", {31'b0, fetch_err}, 0);
    check("t6_req2", {31'b0, im.im_req}, 1);
    check("t6_addr2", im.im_addr, 32'h3008);
`else
    check("t6_pc", pc, 32'h3000);
    check("t6_req", {31'b0, im.im_req}, 1);
    check("t6_addr", im.im_addr, 32'h3000);
    check("t6_err", {31'b0, fetch_err}, 0);
`endif
    npc_ovr_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
